// File: rtl/crop_max_filter_if.sv
// AXI-Stream style pixel channel. A beat transfers on a rising clock edge where
// tvalid and tready are both high; a master keeps tvalid/tdata/tlast stable until then.
interface crop_max_filter_if #(
   parameter int W = 10
);
   logic         tvalid;
   logic         tready;
   logic [W-1:0] tdata;
   logic         tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   // Frames are delimited by pixel count, so the receiving side ignores tlast.
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/crop_max_filter.sv
// Crops an OUT_ROWS x OUT_COLS window out of a streamed frame, tracks the window maximum,
// then replays the buffered window once the whole input frame has been consumed.
module crop_max_filter #(
   parameter int PIXEL_BIT_WIDTH = 10,
   parameter int IN_ROWS         = 32,
   parameter int IN_COLS         = 32,
   parameter int OUT_ROWS        = 10,
   parameter int OUT_COLS        = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ap_start,
   output logic                        ap_done,
   output logic                        ap_ready,
   input  logic [$clog2(IN_ROWS)-1:0]  row_offset,
   input  logic [$clog2(IN_COLS)-1:0]  col_offset,
   crop_max_filter_if.slave            s_axis,
   crop_max_filter_if.master           m_axis,
   output logic [PIXEL_BIT_WIDTH-1:0]  max_value,
   output logic [1:0]                  dbg_state
);

   localparam int W     = PIXEL_BIT_WIDTH;
   localparam int RW    = $clog2(IN_ROWS);
   localparam int CW    = $clog2(IN_COLS);
   localparam int DEPTH = OUT_ROWS * OUT_COLS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [RW-1:0] ROW_MAX  = RW'(IN_ROWS - OUT_ROWS);
   localparam logic [CW-1:0] COL_MAX  = CW'(IN_COLS - OUT_COLS);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
   localparam logic [RW:0]   ROW_SPAN = (RW+1)'(OUT_ROWS);
   localparam logic [CW:0]   COL_SPAN = (CW+1)'(OUT_COLS);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t        state_q,    state_d;
   logic [RW-1:0] row_off_q,  row_off_d;
   logic [CW-1:0] col_off_q,  col_off_d;
   logic [RW-1:0] row_q,      row_d;
   logic [CW-1:0] col_q,      col_d;
   logic [AW-1:0] wr_addr_q,  wr_addr_d;
   logic [AW:0]   rd_cnt_q,   rd_cnt_d;
   logic [W-1:0]  max_q,      max_d;
   logic          ap_done_q,  ap_done_d;
   logic          ap_ready_q, ap_ready_d;
   logic          s_tready_q, s_tready_d;
   logic          pf_valid_q, pf_valid_d;
   logic          pf_last_q,  pf_last_d;
   logic          m_valid_q,  m_valid_d;
   logic          m_last_q,   m_last_d;
   logic [W-1:0]  m_data_q,   m_data_d;
   logic [W-1:0]  pf_data_q;

   logic [W-1:0]  buf_mem [DEPTH];
   logic          in_fire, in_win, last_in, buf_we;
   logic          out_free, out_fire, rd_en;
   logic [AW-1:0] rd_addr;

   assign in_fire  = s_tready_q & s_axis.tvalid;
   assign in_win   = (row_q >= row_off_q) && ({1'b0, row_q} < ({1'b0, row_off_q} + ROW_SPAN)) &&
                     (col_q >= col_off_q) && ({1'b0, col_q} < ({1'b0, col_off_q} + COL_SPAN));
   assign last_in  = in_fire && (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign buf_we   = in_fire & in_win;

   // The output register is free when empty or being taken this cycle. The first read
   // is issued on the final input beat so the window starts leaving two cycles later.
   assign out_free = ~m_valid_q | m_axis.tready;
   assign out_fire = m_valid_q & m_axis.tready;
   assign rd_en    = ((state_q == DRAIN) || last_in) && (rd_cnt_q < DEPTH_C) &&
                     (~pf_valid_q | out_free);
   assign rd_addr  = rd_cnt_q[AW-1:0];

   always_comb begin
      state_d    = state_q;
      row_off_d  = row_off_q;
      col_off_d  = col_off_q;
      row_d      = row_q;
      col_d      = col_q;
      wr_addr_d  = wr_addr_q;
      rd_cnt_d   = rd_cnt_q;
      max_d      = max_q;
      ap_done_d  = 1'b0;
      ap_ready_d = ap_ready_q;
      s_tready_d = s_tready_q;
      pf_last_d  = pf_last_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      m_data_d   = m_data_q;

      pf_valid_d = rd_en | (pf_valid_q & ~out_free);
      if (rd_en) begin
         pf_last_d = (rd_cnt_q == LAST_IDX);
         rd_cnt_d  = rd_cnt_q + (AW+1)'(1);
      end
      if (out_free) begin
         m_valid_d = pf_valid_q;
         m_last_d  = pf_valid_q & pf_last_q;
         if (pf_valid_q) m_data_d = pf_data_q;
      end

      case (state_q)
         IDLE: begin
            if (ap_start) begin
               state_d    = CAPTURE;
               row_off_d  = (row_offset > ROW_MAX) ? ROW_MAX : row_offset;
               col_off_d  = (col_offset > COL_MAX) ? COL_MAX : col_offset;
               row_d      = '0;
               col_d      = '0;
               wr_addr_d  = '0;
               rd_cnt_d   = '0;
               max_d      = '0;
               pf_valid_d = 1'b0;
               ap_ready_d = 1'b0;
               s_tready_d = 1'b1;
            end
         end
         CAPTURE: begin
            if (in_fire) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               // Strictly greater: ties keep the earlier maximum.
               if (buf_we) begin
                  wr_addr_d = wr_addr_q + AW'(1);
                  if (s_axis.tdata > max_q) max_d = s_axis.tdata;
               end
               if (last_in) begin
                  state_d    = DRAIN;
                  s_tready_d = 1'b0;
                  ap_done_d  = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_fire && m_last_q) begin
               state_d    = IDLE;
               ap_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         row_off_q  <= '0;
         col_off_q  <= '0;
         row_q      <= '0;
         col_q      <= '0;
         wr_addr_q  <= '0;
         rd_cnt_q   <= '0;
         max_q      <= '0;
         ap_done_q  <= 1'b0;
         ap_ready_q <= 1'b1;
         s_tready_q <= 1'b0;
         pf_valid_q <= 1'b0;
         pf_last_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         row_off_q  <= row_off_d;
         col_off_q  <= col_off_d;
         row_q      <= row_d;
         col_q      <= col_d;
         wr_addr_q  <= wr_addr_d;
         rd_cnt_q   <= rd_cnt_d;
         max_q      <= max_d;
         ap_done_q  <= ap_done_d;
         ap_ready_q <= ap_ready_d;
         s_tready_q <= s_tready_d;
         pf_valid_q <= pf_valid_d;
         pf_last_q  <= pf_last_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_data_q   <= m_data_d;
      end
   end

   // Window buffer and prefetch data carry no reset; the bypass covers a one-pixel
   // window whose only entry is written on the same beat that issues the first read.
   always_ff @(posedge clk) begin
      if (buf_we) buf_mem[wr_addr_q] <= s_axis.tdata;
      if (rd_en) pf_data_q <= (buf_we && (wr_addr_q == rd_addr)) ? s_axis.tdata : buf_mem[rd_addr];
   end

   assign ap_done       = ap_done_q;
   assign ap_ready      = ap_ready_q;
   assign max_value     = max_q;
   assign s_axis.tready = s_tready_q;
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = m_data_q;
   assign m_axis.tlast  = m_last_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_crop_max_filter.sv
// Bench for crop_max_filter: random-timed frames checked against a window/maximum
// reference model through an expected-output queue drained by an independent monitor.
module tb_crop_max_filter;
  localparam int W     = 10;
  localparam int IR    = 32;
  localparam int IC    = 32;
  localparam int OUT_R = 10;
  localparam int OUT_C = 10;
  localparam int NPIX  = IR * IC;
  localparam int NWIN  = OUT_R * OUT_C;

  logic         clk = 1'b0;
  logic         reset;
  logic         ap_start;
  logic         ap_done;
  logic         ap_ready;
  logic [4:0]   row_offset;
  logic [4:0]   col_offset;
  logic [W-1:0] max_value;
  logic [1:0]   dbg_state;

  crop_max_filter_if #(.W(W)) s_if ();
  crop_max_filter_if #(.W(W)) m_if ();

  crop_max_filter #(
    .PIXEL_BIT_WIDTH(W), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OUT_R), .OUT_COLS(OUT_C)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready),
    .row_offset(row_offset), .col_offset(col_offset), .s_axis(s_if.slave), .m_axis(m_if.master),
    .max_value(max_value), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  int frame[NPIX];
  int exp_max;
  int ready_pct = 100;
  int done_cnt  = 0;
  int out_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ap_ready"}, ap_ready, 1);
    check({tag, "_ap_done"}, ap_done, 0);
    check({tag, "_s_tready"}, s_if.tready, 0);
    check({tag, "_m_tvalid"}, m_if.tvalid, 0);
    check({tag, "_m_tlast"}, m_if.tlast, 0);
    check({tag, "_m_tdata"}, m_if.tdata, 0);
    check({tag, "_max_value"}, max_value, 0);
  endtask

  // ---------------- reference model ----------------
  task automatic gen_frame(input int mode);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0:       frame[i] = i % 1024;
        1:       frame[i] = 5;
        default: frame[i] = $urandom_range(0, 1023);
      endcase
    end
    if (mode == 1) begin
      frame[0]          = 1023;
      frame[15*IC + 17] = 700;
    end
  endtask

  task automatic model_window(input int ro, input int co);
    int cro, cco, idx;
    logic [W-1:0] pv;
    cro = (ro > IR - OUT_R) ? IR - OUT_R : ro;
    cco = (co > IC - OUT_C) ? IC - OUT_C : co;
    exp_max = 0;
    idx = 0;
    for (int r = cro; r < cro + OUT_R; r++) begin
      for (int c = cco; c < cco + OUT_C; c++) begin
        pv = frame[r*IC + c][W-1:0];
        exp_q.push_back({(idx == NWIN - 1), pv});
        if (frame[r*IC + c] > exp_max) exp_max = frame[r*IC + c];
        idx++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int ro, input int co);
    model_window(ro, co);
    ap_start   = 1'b1;
    row_offset = ro[4:0];
    col_offset = co[4:0];
    tick();
    ap_start = 1'b0;
    check("start_ap_ready", ap_ready, 0);
    check("start_s_tready", s_if.tready, 1);
    check("start_max_clear", max_value, 0);
  endtask

  task automatic send_pixel(input int v, input bit last, output bit ok);
    logic hs;
    s_if.tvalid = 1'b1;
    s_if.tdata  = v[W-1:0];
    s_if.tlast  = last;
    ok = 1'b0;
    for (int b = 0; b < 20 && !ok; b++) begin
      @(negedge clk);
      hs = s_if.tready;
      tick();
      ok = hs;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Returns with complete=1 at one cycle after the final input beat.
  task automatic feed_frame(input int gap_pct, input int pulse_at, input int abort_at,
                            output bit complete);
    bit ok;
    complete = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      if (i == abort_at) return;
      if ($urandom_range(0, 99) < gap_pct) begin
        s_if.tvalid = 1'b0;
        tick();
      end
      if (i == pulse_at) begin
        ap_start   = 1'b1;
        row_offset = 5'd0;
        col_offset = 5'd0;
      end
      send_pixel(frame[i], (i == NPIX - 1), ok);
      ap_start = 1'b0;
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL input_timeout: pixel %0d not accepted, got no tready expected tready", i);
        return;
      end
    end
    complete = 1'b1;
  endtask

  task automatic finish_frame(input bit pulse_in_drain);
    int budget;
    check("done_pulse", ap_done, 1);
    check("done_max", max_value, exp_max);
    check("done_s_tready", s_if.tready, 0);
    check("done_m_tvalid", m_if.tvalid, 0);
    tick();
    check("done_one_cycle", ap_done, 0);
    check("first_m_tvalid", m_if.tvalid, 1);
    if (pulse_in_drain) begin
      ap_start   = 1'b1;
      row_offset = 5'd0;
      col_offset = 5'd0;
      tick();
      ap_start = 1'b0;
    end
    budget = 0;
    while (!ap_ready && budget < 5000) begin
      tick();
      budget++;
    end
    check("drain_ap_ready", ap_ready, 1);
    check("end_m_tvalid", m_if.tvalid, 0);
    check("out_count", out_cnt, NWIN);
    check("exp_left", exp_q.size(), 0);
    check("done_count", done_cnt, 1);
    check("end_max_hold", max_value, exp_max);
    tick();
    check("idle_s_tready", s_if.tready, 0);
    check("idle_ap_ready", ap_ready, 1);
    out_cnt  = 0;
    done_cnt = 0;
    exp_q.delete();
  endtask

  task automatic run_frame(input int mode, input int ro, input int co, input int gap_pct,
                           input int pulse_at, input bit pulse_in_drain);
    bit complete;
    gen_frame(mode);
    do_start(ro, co);
    feed_frame(gap_pct, pulse_at, -1, complete);
    if (complete) finish_frame(pulse_in_drain);
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit           stall_q = 1'b0;
    logic [W-1:0] stall_data = '0;
    logic         stall_last = 1'b0;
    logic [W:0]   e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_q = 1'b0;
        continue;
      end
      if (ap_done) done_cnt++;
      if (stall_q) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data", m_if.tdata, stall_data);
        check("hold_last", m_if.tlast, stall_last);
      end
      if (m_if.tvalid && m_if.tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pixel %0d expected no output", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_if.tdata, e[W-1:0]);
          check("out_last", m_if.tlast, e[W]);
        end
      end
      stall_q    = m_if.tvalid && !m_if.tready;
      stall_data = m_if.tdata;
      stall_last = m_if.tlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit complete;
    reset       = 1'b1;
    ap_start    = 1'b0;
    row_offset  = '0;
    col_offset  = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_reset_values("post_rst");

    // Centred crop, ramp frame.
    run_frame(0, 11, 11, 0, -1, 1'b0);
    // Single in-window peak, larger pixel outside the window.
    run_frame(1, 11, 11, 0, -1, 1'b0);
    // Offsets beyond the legal range clamp to the last window position.
    run_frame(0, 31, 31, 0, -1, 1'b0);
    // Downstream backpressure and gapped input.
    ready_pct = 30;
    run_frame(0, 11, 11, 30, -1, 1'b0);
    ready_pct = 100;
    // Start pulses during capture and drain must be ignored.
    run_frame(0, 11, 11, 0, 300, 1'b1);
    // Random frames and offsets with mixed timing.
    for (int k = 0; k < 3; k++) begin
      ready_pct = $urandom_range(40, 100);
      run_frame(2, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 25), -1, 1'b0);
    end
    ready_pct = 100;

    // Reset after 500 inputs, then a clean frame.
    gen_frame(0);
    do_start(11, 11);
    feed_frame(0, -1, 500, complete);
    check("abort_in_capture", complete, 0);
    reset = 1'b1;
    #1;
    check_reset_values("mid_rst");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_values("mid_rst_rel");
    out_cnt  = 0;
    done_cnt = 0;
    run_frame(0, 11, 11, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crop_max_filter.md
# crop_max_filter

Crop-filter stage that feeds the normalization reader. It accepts a full IN_ROWS x IN_COLS pixel frame on an AXI-Stream slave and keeps only the OUT_ROWS x OUT_COLS window at a run-time offset, storing that window in an internal buffer. While capturing, it tracks the maximum in-window pixel. Once the whole input frame has been consumed, it pulses `ap_done` with the final maximum on `max_value`, then replays the buffered window on its AXI-Stream master. The normalization stage uses `ap_done` as its go signal and `max_value` as its denominator; it does not accept pixels before then, which is why the window is buffered.

## Interface
- PIXEL_BIT_WIDTH, 10, pixel width.
- IN_ROWS, 32, input frame rows.
- IN_COLS, 32, input frame columns.
- OUT_ROWS, 10, crop window rows (≤ IN_ROWS).
- OUT_COLS, 10, crop window columns (≤ IN_COLS).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- ap_start  in  1  one-cycle start pulse, honoured only in IDLE.
- ap_done  out  1  one-cycle pulse when capture is complete.
- ap_ready  out  1  high in IDLE only.
- row_offset  in  $clog2(IN_ROWS)  window top row, latched on accepted ap_start.
- col_offset  in  $clog2(IN_COLS)  window left column, latched on accepted ap_start.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel, raster order.
- m_axis_tvalid  out  1  output pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  PIXEL_BIT_WIDTH  cropped pixel, raster order.
- m_axis_tlast  out  1  high with the last window pixel.
- max_value  out  PIXEL_BIT_WIDTH  maximum in-window pixel.

## Operation
- States:
  - IDLE → CAPTURE on `ap_start`.
  - CAPTURE → DRAIN after the IN_ROWS*IN_COLS-th input handshake.
  - DRAIN → IDLE after the OUT_ROWS*OUT_COLS-th output handshake.
- On accepted `ap_start`:
  - Latch offsets, clamped to IN_ROWS-OUT_ROWS and IN_COLS-OUT_COLS.
  - Clear `max_value` to 0, and zero the row/col and buffer counters.
- CAPTURE:
  - `s_axis_tready`=1 every cycle.
  - Each handshake advances col (wraps at IN_COLS-1, then increments row).
  - A pixel is in-window when row_off ≤ row < row_off+OUT_ROWS and col_off ≤ col < col_off+OUT_COLS.
  - In-window pixels are written to the buffer at wr_addr++ and compared unsigned against `max_value`; ties keep the old value.
  - Out-of-window pixels are accepted and dropped.
- Buffer: OUT_ROWS*OUT_COLS x PIXEL_BIT_WIDTH, synchronous read (1-cycle latency). The output stage uses a 1-entry prefetch register so `m_axis_tdata` never bubbles while `m_axis_tready`=1.
- DRAIN:
  - `s_axis_tready`=0.
  - Pixels are emitted in write order; `m_axis_tlast` is high on index OUT_ROWS*OUT_COLS-1.
  - `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` hold stable while `m_axis_tready`=0.
- `max_value` holds from the `ap_done` cycle until the next accepted `ap_start`.
- `ap_start` in CAPTURE or DRAIN is ignored; offsets are not relatched.
- Reset mid-operation: return to IDLE, drop any partially captured or drained frame, and leave buffer contents undefined.

## Timing
- Reset values:
  - `ap_ready`=1.
  - `ap_done`=0, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0.
  - `m_axis_tdata`=0, `max_value`=0.
- `ap_start` sampled at cycle T: `ap_ready`=0 and `s_axis_tready`=1 from T+1.
- Last input handshake at cycle N:
  - At N+1: `ap_done`=1 for exactly one cycle, `max_value` final, `s_axis_tready`=0.
  - First `m_axis_tvalid`=1 at N+2.
- Drain throughput: 1 pixel/cycle while `m_axis_tready`=1.
- Last output handshake at cycle M: `m_axis_tvalid`=0 and `ap_ready`=1 at M+1.
- `ap_start` pulse arriving in the same cycle that `ap_ready` rises is ignored; it is accepted from the following cycle.
- `max_value` update is registered: an in-window pixel accepted at cycle k is reflected at k+1.

## Test plan
- **Centred crop.**
  - Stimulus: defaults, offsets (11,11), frame pixel = (row*32+col) mod 1024.
  - Required: 100 outputs, first = 363, last = 660; `tlast` only on the 100th; `max_value`=660; `ap_done` exactly one cycle after the 1024th input.
- **Max tracking.**
  - Stimulus: all pixels 5, a single 1023 outside the window, a single 700 inside the window.
  - Required: `max_value`=700.
- **Offset clamp.**
  - Stimulus: offsets (31,31).
  - Required: behaves as offsets (22,22); first output = 726.
- **Backpressure.**
  - Stimulus: `m_axis_tready` random at 30% duty; `s_axis_tvalid` gapped.
  - Required: output sequence identical to the centred-crop case; no duplicated or dropped pixels; data stable while stalled.
- **Protocol.**
  - Stimulus: `ap_start` pulsed during CAPTURE and during DRAIN.
  - Required: ignored; offsets unchanged; one frame out.
  - Stimulus: `ap_start` pulsed in IDLE.
  - Required: a second frame is captured with `max_value` cleared to 0 first.
- **Reset.**
  - Stimulus: `reset` asserted after 500 inputs.
  - Required: outputs go to reset values immediately; after release, a fresh `ap_start` plus a full frame gives the correct 100-pixel crop.
